// File: rtl/column_shift_pkg.sv
// Shared definitions for the column-select receive chain.
package column_shift_pkg;

  // Bits per chain stage; the column interface is byte-based.
  localparam int SPI_SIZE = 8;

  // Width of the per-byte bit counter.
  localparam int CNT_W = $clog2(SPI_SIZE);

  // Value every chain stage and the latched outputs hold after reset.
  localparam logic [SPI_SIZE-1:0] RESET_DATA = 8'hFF;

  // Receive FSM: IDLE on a byte boundary, SHIFTING mid-byte, LATCH for one
  // cycle after a storage strobe.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFTING = 2'd1,
    LATCH    = 2'd2
  } state_t;

endpackage

// File: rtl/column_shift_rx_sync_edge.sv
// sync_edge: 2-flop synchroniser for an asynchronous pin followed by a
// rising-edge detector. All flops reset to the pin's idle level so that
// releasing reset never looks like an edge.
module sync_edge #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Two synchroniser stages plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
      s3 <= RESET_LEVEL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync_out = s2;
  assign rise     = s2 & ~s3;

endmodule

// File: rtl/column_shift_rx.sv
// column_shift_rx: receive-side model of the column-select shift-register
// chain. Oversamples ser_clk/ser/stcp/enable on clk, assembles bytes
// MSB-first into a COLUMN_NUMBER-deep chain and, on each stcp rising edge,
// latches the chain and decodes the active-low select bit.
// Optional feature: define COLUMN_SHIFT_RX_ERR_EN to enable the sticky
// frame_error detector; otherwise frame_error is tied low.
module column_shift_rx
  import column_shift_pkg::*;
#(
  parameter  int COLUMN_NUMBER = 3,
  localparam int IDX_W = (COLUMN_NUMBER > 1) ? $clog2(COLUMN_NUMBER) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ser_clk,
  input  logic                              ser,
  input  logic                              stcp,
  input  logic                              enable,
  output logic [COLUMN_NUMBER*SPI_SIZE-1:0] column_data,
  output logic [IDX_W-1:0]                  active_column,
  output logic                              column_valid,
  output logic                              extra_bit,
  output logic                              outputs_on,
  output logic                              latch_pulse,
  output logic                              frame_error
);

  logic ser_d1;
  logic ser_d2;

  logic ser_clk_level;
  logic ser_clk_rise;
  logic stcp_level;
  logic stcp_rise;
  logic enable_level;
  logic enable_rise;
  logic unused_sync;

  logic [SPI_SIZE-1:0] asm_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    bit_cnt_next;
  logic                byte_done;
  logic [SPI_SIZE-1:0] new_byte;

  logic [SPI_SIZE-1:0] chain [COLUMN_NUMBER];

  state_t state;
  state_t state_next;
  logic   latch_en;

  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W:0]   zero_cnt;
  logic             sel_valid;
  logic             sel_extra;

  sync_edge #(.RESET_LEVEL(1'b0)) u_sync_ser_clk (
    .clk      (clk),
    .rst      (rst),
    .din      (ser_clk),
    .sync_out (ser_clk_level),
    .rise     (ser_clk_rise)
  );

  sync_edge #(.RESET_LEVEL(1'b0)) u_sync_stcp (
    .clk      (clk),
    .rst      (rst),
    .din      (stcp),
    .sync_out (stcp_level),
    .rise     (stcp_rise)
  );

  sync_edge #(.RESET_LEVEL(1'b1)) u_sync_enable (
    .clk      (clk),
    .rst      (rst),
    .din      (enable),
    .sync_out (enable_level),
    .rise     (enable_rise)
  );

  // Synchroniser outputs this block has no use for.
  assign unused_sync = &{1'b0, ser_clk_level, stcp_level, enable_rise};

  // Delay ser by two flops so it lines up with the synchronised ser_clk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_d1 <= 1'b0;
      ser_d2 <= 1'b0;
    end else begin
      ser_d1 <= ser;
      ser_d2 <= ser_d1;
    end
  end

  // Next bit count, byte-complete flag and the byte that would complete now.
  always_comb begin
    bit_cnt_next = bit_cnt;
    byte_done    = 1'b0;
    new_byte     = {asm_reg[SPI_SIZE-2:0], ser_d2};
    if (ser_clk_rise) begin
      bit_cnt_next = bit_cnt + CNT_W'(1);
      byte_done    = (bit_cnt == CNT_W'(SPI_SIZE - 1));
    end
  end

  // Assembly register and bit counter advance on every ser_clk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg <= '0;
      bit_cnt <= '0;
    end else if (ser_clk_rise) begin
      asm_reg <= new_byte;
      bit_cnt <= bit_cnt_next;
    end
  end

  // Completed bytes enter stage 0 and push older stages toward the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < COLUMN_NUMBER; k++) begin
        chain[k] <= RESET_DATA;
      end
    end else if (byte_done) begin
      for (int k = COLUMN_NUMBER - 1; k > 0; k--) begin
        chain[k] <= chain[k-1];
      end
      chain[0] <= new_byte;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: a storage strobe always wins; otherwise the bit counter
  // decides whether a partial byte is in progress.
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    case (state)
      LATCH: begin
        latch_en   = 1'b1;
        state_next = (bit_cnt_next != '0) ? SHIFTING : IDLE;
      end
      default: begin
        if (stcp_rise) begin
          state_next = LATCH;
        end else begin
          state_next = (bit_cnt_next != '0) ? SHIFTING : IDLE;
        end
      end
    endcase
  end

  // Decode the active-low select bit: lowest zero stage wins, valid if unique.
  always_comb begin
    sel_idx   = '0;
    zero_cnt  = '0;
    sel_extra = chain[0][1];
    for (int k = COLUMN_NUMBER - 1; k >= 0; k--) begin
      if (!chain[k][0]) begin
        sel_idx   = IDX_W'(k);
        sel_extra = chain[k][1];
        zero_cnt  = zero_cnt + (IDX_W+1)'(1);
      end
    end
    sel_valid = (zero_cnt == (IDX_W+1)'(1));
  end

  // Latched outputs update only during the LATCH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      column_data   <= {COLUMN_NUMBER{RESET_DATA}};
      active_column <= '0;
      column_valid  <= 1'b0;
      extra_bit     <= 1'b1;
      latch_pulse   <= 1'b0;
    end else begin
      latch_pulse <= latch_en;
      if (latch_en) begin
        for (int k = 0; k < COLUMN_NUMBER; k++) begin
          column_data[k*SPI_SIZE +: SPI_SIZE] <= chain[k];
        end
        active_column <= sel_idx;
        column_valid  <= sel_valid;
        extra_bit     <= sel_extra;
      end
    end
  end

  assign outputs_on = ~enable_level;

`ifdef COLUMN_SHIFT_RX_ERR_EN
  // Sticky error: latch taken mid-byte or without exactly one selected stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_error <= 1'b0;
    end else if (latch_en && ((bit_cnt != '0) || !sel_valid)) begin
      frame_error <= 1'b1;
    end
  end
`else
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_column_shift_rx.sv
// Directed testbench for column_shift_rx: table-driven byte/latch vectors
// plus hand-written sequences for coincident edges, partial bytes, mid-byte
// reset and output enable.
module tb_column_shift_rx;

`ifdef COLUMN_SHIFT_RX_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_clk;
  logic        ser;
  logic        stcp;
  logic        enable;
  logic [23:0] column_data;
  logic [1:0]  active_column;
  logic        column_valid;
  logic        extra_bit;
  logic        outputs_on;
  logic        latch_pulse;
  logic        frame_error;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [23:0] data;
    logic [1:0]  act;
    logic        valid;
    logic        extra;
    logic        err_if_on;
  } vec_t;

  vec_t vecs [6];

  column_shift_rx #(.COLUMN_NUMBER(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .ser_clk       (ser_clk),
    .ser           (ser),
    .stcp          (stcp),
    .enable        (enable),
    .column_data   (column_data),
    .active_column (active_column),
    .column_valid  (column_valid),
    .extra_bit     (extra_bit),
    .outputs_on    (outputs_on),
    .latch_pulse   (latch_pulse),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [23:0] data,
                             input logic [1:0] act, input logic valid,
                             input logic extra, input logic err);
    checkOutput({tag, " column_data"},   32'(column_data),   32'(data));
    checkOutput({tag, " active_column"}, 32'(active_column), 32'(act));
    checkOutput({tag, " column_valid"},  32'(column_valid),  32'(valid));
    checkOutput({tag, " extra_bit"},     32'(extra_bit),     32'(extra));
    checkOutput({tag, " frame_error"},   32'(frame_error),   32'(err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    ser_clk = 1'b0;
    ser     = 1'b0;
    stcp    = 1'b0;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    ser = b;
    repeat (2) @(negedge clk);
    ser_clk = 1'b1;
    repeat (2) @(negedge clk);
    ser_clk = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      shift_bit(b[i]);
    end
  endtask

  // Raise stcp (optionally together with the final ser_clk edge), measure the
  // latch_pulse latency and check the pulse is a single cycle wide.
  task automatic run_latch(input string tag, input bit with_bit, input logic bit_val);
    int lat;
    lat = -1;
    if (with_bit) begin
      ser = bit_val;
      repeat (2) @(negedge clk);
      ser_clk = 1'b1;
    end
    stcp = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (latch_pulse) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, " latch latency"}, 32'(lat), 32'd4);
    @(posedge clk);
    #1;
    checkOutput({tag, " pulse width"}, 32'(latch_pulse), 32'd0);
    @(negedge clk);
    ser_clk = 1'b0;
    stcp    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    shift_byte(v.b0);
    shift_byte(v.b1);
    shift_byte(v.b2);
    run_latch(tag, 1'b0, 1'b0);
    check_state(tag, v.data, v.act, v.valid, v.extra, ERR_ON & v.err_if_on);
  endtask

  initial begin
    int pulses;

    // bytes in shift order; stage 0 = last byte, stage 2 = first byte
    vecs[0] = '{8'hFE, 8'hFF, 8'hFF, 24'hFEFFFF, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFE, 24'hFFFFFE, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFC, 8'hFF, 24'hFFFCFF, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF, 2'd0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'hFE, 8'hFE, 8'hFF, 24'hFEFEFF, 2'd1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'hFE, 8'hFE, 8'hFE, 24'hFEFEFE, 2'd0, 1'b0, 1'b1, 1'b1};

    rst     = 1'b1;
    ser_clk = 1'b0;
    ser     = 1'b0;
    stcp    = 1'b0;
    enable  = 1'b1;
    do_reset();
    #1;
    check_state("reset", 24'hFFFFFF, 2'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("reset outputs_on",  32'(outputs_on),  32'd0);
    checkOutput("reset latch_pulse", 32'(latch_pulse), 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // stcp rises together with the final ser_clk edge of 0xFC,0xFF,0xFF
    shift_byte(8'hFC);
    shift_byte(8'hFF);
    for (int i = 7; i >= 1; i--) begin
      shift_bit(1'b1);
    end
    run_latch("coincident", 1'b1, 1'b1);
    check_state("coincident", 24'hFCFFFF, 2'd2, 1'b1, 1'b0, ERR_ON);

    // partial byte latch leaves data unchanged and flags an error
    do_reset();
    shift_byte(8'hFE);
    shift_byte(8'hFF);
    shift_byte(8'hFF);
    run_latch("pre-partial", 1'b0, 1'b0);
    check_state("pre-partial", 24'hFEFFFF, 2'd2, 1'b1, 1'b1, 1'b0);
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b1);
    run_latch("partial", 1'b0, 1'b0);
    check_state("partial", 24'hFEFFFF, 2'd2, 1'b1, 1'b1, ERR_ON);
    shift_bit(1'b1);
    shift_bit(1'b1);
    shift_bit(1'b0);
    run_latch("completed", 1'b0, 1'b0);
    check_state("completed", 24'hFFFFAE, 2'd0, 1'b1, 1'b1, ERR_ON);

    // reset mid-byte: asynchronous clear, partial bits discarded, no pulse
    shift_bit(1'b0);
    shift_bit(1'b0);
    shift_bit(1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst column_data", 32'(column_data), 32'hFFFFFF);
    checkOutput("async rst frame_error", 32'(frame_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (latch_pulse) pulses++;
    end
    checkOutput("release latch_pulse count", 32'(pulses), 32'd0);
    @(negedge clk);
    shift_byte(8'hFE);
    shift_byte(8'hFF);
    shift_byte(8'hFF);
    run_latch("after rst", 1'b0, 1'b0);
    check_state("after rst", 24'hFEFFFF, 2'd2, 1'b1, 1'b1, 1'b0);

    // enable 1 -> 0 -> 1, outputs_on follows two cycles later
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("enable low +1", 32'(outputs_on), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("enable low +2", 32'(outputs_on), 32'd1);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("enable high +1", 32'(outputs_on), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("enable high +2", 32'(outputs_on), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
